// File: rtl/fetch_request_unit.sv
// Program counter owner and instruction/data request sequencer for the single-cycle MIPS core.
// Each instruction is a FETCH phase plus an optional DATA phase; commit gates register-file writes.
module fetch_request_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [31:0] imemload,
    input  logic [2:0]  pc_select,
    input  logic [31:0] immediate,
    input  logic [31:0] jump_data,
    input  logic        cu_dREN,
    input  logic        cu_dWEN,
    input  logic        cpu_halt,
    output logic [31:0] instr,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] pc_plus4,
    output logic        commit,
    output logic        halt,
    output logic [1:0]  fsm_state
);

    // pc_select encoding shared with the control unit
    localparam logic [2:0] SEL_NEXT         = 3'd0;
    localparam logic [2:0] SEL_BRANCH       = 3'd1;
    localparam logic [2:0] SEL_JUMP         = 3'd2;
    localparam logic [2:0] SEL_JUMPREGISTER = 3'd3;
    localparam logic [2:0] SEL_PC_HALT      = 3'd4;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] instr_q, instr_n;
    logic        halt_q, halt_n;
    logic [31:0] next_pc;

    assign pc_plus4  = pc + 32'd4;
    assign imemaddr  = pc;
    assign halt      = halt_q;
    assign fsm_state = state;

    always_comb begin
        next_pc = pc_plus4;
        case (pc_select)
            SEL_NEXT:         next_pc = pc_plus4;
            SEL_BRANCH:       next_pc = pc_plus4 + (immediate << 2);
            SEL_JUMP:         next_pc = {pc_plus4[31:28], jump_data[25:0], 2'b00};
            SEL_JUMPREGISTER: next_pc = jump_data;
            SEL_PC_HALT:      next_pc = pc;
            default:          next_pc = pc_plus4;
        endcase
    end

    // Mealy outputs: commit and requests react to ihit/dhit in the same cycle,
    // so consecutive instructions issue without a bubble.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = instr_q;
        halt_n  = halt_q;
        imemREN = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        commit  = 1'b0;
        instr   = instr_q;
        case (state)
            FETCH: begin
                imemREN = 1'b1;
                instr   = imemload;
                if (ihit) begin
                    if (cpu_halt) begin
                        state_n = HALTED;
                        halt_n  = 1'b1;
                    end else if (cu_dREN || cu_dWEN) begin
                        state_n = DATA;
                        instr_n = imemload;
                    end else begin
                        commit = 1'b1;
                        pc_n   = next_pc;
                    end
                end
            end
            DATA: begin
                // instr_q keeps the control-unit outputs valid until dhit
                dmemREN = cu_dREN;
                dmemWEN = cu_dWEN;
                if (dhit) begin
                    commit  = 1'b1;
                    pc_n    = next_pc;
                    state_n = FETCH;
                end
            end
            HALTED: begin
            end
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= FETCH;
            pc      <= PC_INIT;
            instr_q <= 32'h0;
            halt_q  <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            instr_q <= instr_n;
            halt_q  <= halt_n;
        end
    end

endmodule

// File: doc/fetch_request_unit.md
# fetch_request_unit

Owns the program counter and arbitrates instruction and data memory requests for the single-cycle MIPS core. Presents the current instruction word to the control unit. Consumes the control unit's pc_select/jump_data/immediate/dREN/dWEN/cpu_halt outputs. Sequences each instruction through a fetch phase and an optional data phase, and emits a one-cycle commit strobe that gates register-file writes.

## Interface
- PC_INIT, 32'h00000000, PC value loaded on reset
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- ihit  in  1  instruction memory returned imemload this cycle
- dhit  in  1  data memory completed the requested read/write this cycle
- imemload  in  32  instruction word from memory
- pc_select  in  pc_select_t  NEXT / BRANCH / JUMP / JUMPREGISTER / PC_HALT, from control unit
- immediate  in  32  sign-extended branch offset, from control unit
- jump_data  in  32  instruction word (JUMP) or rs value (JUMPREGISTER), from control unit
- cu_dREN, cu_dWEN  in  1 each  data read/write request, from control unit
- cpu_halt  in  1  HALT decoded, from control unit
- instr  out  32  instruction to control unit
- imemREN  out  1  instruction read request
- imemaddr  out  32  current PC
- dmemREN, dmemWEN  out  1 each  data request to memory
- pc_plus4  out  32  PC+4, JAL return address
- commit  out  1  one-cycle strobe; register file writes only when commit=1
- halt  out  1  sticky halted indication

## Operation
- States: FETCH, DATA, HALTED. Registers: pc, instr_q, state, halt_q.
- FETCH: imemREN=1, imemaddr=pc, instr=imemload, dmemREN=dmemWEN=0.
  - ihit & cpu_halt -> HALTED. pc holds. commit=0.
  - ihit & (cu_dREN|cu_dWEN) -> DATA. instr_q<=imemload. pc holds. commit=0.
  - ihit otherwise -> commit=1. pc<=next_pc. Stay FETCH.
  - no ihit -> hold everything.
- DATA: imemREN=0, instr=instr_q, dmemREN=cu_dREN, dmemWEN=cu_dWEN.
  - dhit -> commit=1, pc<=next_pc, -> FETCH.
  - no dhit -> hold; requests stay asserted.
- HALTED: all requests 0, commit=0, halt=1. Exit only by reset.
- next_pc, all modulo 2^32:
  - NEXT: pc+4
  - BRANCH: pc+4+(immediate<<2)
  - JUMP: {pc_plus4[31:28], jump_data[25:0], 2'b00}
  - JUMPREGISTER: jump_data
  - PC_HALT: pc
- pc_plus4 = pc+4 at all times; wraps 32'hFFFFFFFC -> 0.
- Boundaries:
  - dhit in FETCH is ignored. ihit in DATA is ignored.
  - ihit and dhit in the same FETCH cycle: only ihit acts.
  - pc_select=PC_HALT without cpu_halt: commit pulses, pc holds, stay FETCH.
  - Reset mid-DATA: immediately FETCH, dmemREN/dmemWEN drop asynchronously.

## Timing
- Reset values: state=FETCH, pc=PC_INIT, imemREN=1, imemaddr=PC_INIT, dmemREN=dmemWEN=0, commit=0, halt=0, instr_q=0.
- Reset is asynchronous; all state updates occur on CLK rising edge.
- commit, imemREN and dmem requests are combinational from state, ihit/dhit and control inputs (Moore+Mealy). There is no bubble between instructions.
- Non-memory instruction: retires in the ihit cycle; the new pc appears on imemaddr the next cycle.
- LW/SW: ihit cycle, then at least 1 DATA cycle. Minimum 2 cycles; each extra dhit wait adds 1 cycle.
- instr must stay stable through DATA, so control-unit outputs stay valid until dhit.
- halt rises the cycle after the HALT ihit and stays high until reset.

## Test plan
- Reset, PC_INIT=0; ihit=1 every cycle, ORI stream (pc_select=NEXT) -> imemaddr 0,4,8,12 on consecutive cycles; commit=1 each ihit cycle.
- LW at pc=0x10, dhit delayed 3 cycles -> imemREN=0 and dmemREN=1 for 3 cycles; instr holds the LW word while imemload changes; commit=1 only on the dhit cycle; next imemaddr=0x14.
- BRANCH at pc=0x20, immediate=32'hFFFFFFFE -> next imemaddr=0x1C. JUMP with jump_data[25:0]=26'h40 at pc=0x30 -> 0x100. JUMPREGISTER with jump_data=0x200 -> 0x200.
- pc=32'hFFFFFFFC, NEXT -> pc wraps to 0; pc_plus4=0 before the update.
- HALT on ihit -> halt=1 from the next cycle; imemREN=0; pc frozen; further ihit/dhit ignored for 10 cycles.
- nRST asserted mid-DATA with dmemWEN=1 -> dmemWEN=0 immediately; after release, imemaddr=PC_INIT and state=FETCH. ihit and dhit together in FETCH -> dmem requests stay 0.
